// File: rtl/rv64i_control_unit.sv
// Multi-cycle Fetch/Decode/Execute sequencer for the RV64I core.
// Every output is combinational from state, IR fields, flags and mem_busy.
module rv64i_control_unit (
   input  logic       clock,
   input  logic       reset,
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   input  logic       zero_i,
   input  logic       negative_i,
   input  logic       carry_out_i,
   input  logic       overflow_i,
   input  logic       mem_busy_i,
   output logic       mem_rd_en_o,
   output logic       mem_wr_en_o,
   output logic [7:0] mem_byte_en_o,
   output logic       mem_addr_src_o,
   output logic       ir_en_o,
   output logic       alua_src_o,
   output logic       alub_src_o,
   output logic       aluy_src_o,
   output logic [2:0] alu_src_o,
   output logic       sub_o,
   output logic       arithmetic_o,
   output logic       alupc_src_o,
   output logic       pc_src_o,
   output logic       pc_en_o,
   output logic [1:0] wr_reg_src_o,
   output logic       wr_reg_en_o
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

   typedef struct packed {
      logic       rd;
      logic       wr;
      logic [7:0] be;
      logic       addr;
      logic       ir;
      logic       alua;
      logic       alub;
      logic       aluy;
      logic [2:0] alu;
      logic       sub;
      logic       arith;
      logic       alupc;
      logic       pcsrc;
      logic       pcen;
      logic [1:0] wrsrc;
      logic       wren;
   } ctl_t;

   state_t state_q, state_d;
   logic   seen_q, seen_d;
   logic   mem_done;
   logic   is_load;
   ctl_t   ctl;
   logic   unused_funct7;

   assign unused_funct7 = ^{funct7_i[6], funct7_i[4:0]};
   // An access completes on the first idle cycle after busy has been observed.
   assign mem_done = seen_q & ~mem_busy_i;
   assign is_load  = (opcode_i == OP_LOAD);

   always_comb begin
      ctl     = '0;
      state_d = state_q;
      seen_d  = seen_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
            seen_d  = 1'b0;
         end
         S_FETCH: begin
            ctl.be = 8'h0F;
            if (mem_done) begin
               ctl.ir  = 1'b1;
               state_d = S_DECODE;
               seen_d  = 1'b0;
            end else begin
               ctl.rd = 1'b1;
               seen_d = seen_q | mem_busy_i;
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            state_d = S_FETCH;
            case (opcode_i)
               OP_LUI: begin
                  ctl.wrsrc = 2'b11;
                  ctl.wren  = 1'b1;
                  ctl.pcen  = 1'b1;
               end
               OP_AUIPC: begin
                  ctl.alua = 1'b1;
                  ctl.alub = 1'b1;
                  ctl.wren = 1'b1;
                  ctl.pcen = 1'b1;
               end
               OP_JAL: begin
                  ctl.pcsrc = 1'b1;
                  ctl.wrsrc = 2'b10;
                  ctl.wren  = 1'b1;
                  ctl.pcen  = 1'b1;
               end
               OP_JALR: begin
                  ctl.alub  = 1'b1;
                  ctl.alupc = 1'b1;
                  ctl.pcsrc = 1'b1;
                  ctl.wrsrc = 2'b10;
                  ctl.wren  = 1'b1;
                  ctl.pcen  = 1'b1;
               end
               OP_BRANCH: begin
                  ctl.sub  = 1'b1;
                  ctl.pcen = 1'b1;
                  case (funct3_i[2:1])
                     2'b00:   ctl.pcsrc = zero_i ^ funct3_i[0];
                     2'b10:   ctl.pcsrc = negative_i ^ overflow_i ^ funct3_i[0];
                     2'b11:   ctl.pcsrc = ~(carry_out_i ^ funct3_i[0]);
                     default: ctl.pcsrc = 1'b0;
                  endcase
               end
               OP_IMM, OP_IMM32, OP_REG, OP_REG32: begin
                  ctl.alub  = (opcode_i == OP_IMM) || (opcode_i == OP_IMM32);
                  ctl.aluy  = (opcode_i == OP_IMM32) || (opcode_i == OP_REG32);
                  ctl.alu   = funct3_i;
                  ctl.arith = (funct3_i == 3'b101) && funct7_i[5];
                  ctl.sub   = (funct3_i == 3'b010) || (funct3_i == 3'b011) ||
                              (!ctl.alub && funct3_i == 3'b000 && funct7_i[5]);
                  ctl.wren  = 1'b1;
                  ctl.pcen  = 1'b1;
               end
               OP_LOAD, OP_STORE: begin
                  ctl.alub = 1'b1;
                  ctl.addr = 1'b1;
                  case (funct3_i[1:0])
                     2'b00:   ctl.be = 8'h01;
                     2'b01:   ctl.be = 8'h03;
                     2'b10:   ctl.be = 8'h0F;
                     default: ctl.be = 8'hFF;
                  endcase
                  if (is_load) ctl.wrsrc = 2'b01;
                  if (mem_done) begin
                     ctl.pcen = 1'b1;
                     ctl.wren = is_load;
                     seen_d   = 1'b0;
                  end else begin
                     ctl.rd  = is_load;
                     ctl.wr  = ~is_load;
                     seen_d  = seen_q | mem_busy_i;
                     state_d = S_EXEC;
                  end
               end
               default: state_d = S_HALT;
            endcase
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
      if (reset) ctl = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         seen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         seen_q  <= seen_d;
      end
   end

   assign mem_rd_en_o    = ctl.rd;
   assign mem_wr_en_o    = ctl.wr;
   assign mem_byte_en_o  = ctl.be;
   assign mem_addr_src_o = ctl.addr;
   assign ir_en_o        = ctl.ir;
   assign alua_src_o     = ctl.alua;
   assign alub_src_o     = ctl.alub;
   assign aluy_src_o     = ctl.aluy;
   assign alu_src_o      = ctl.alu;
   assign sub_o          = ctl.sub;
   assign arithmetic_o   = ctl.arith;
   assign alupc_src_o    = ctl.alupc;
   assign pc_src_o       = ctl.pcsrc;
   assign pc_en_o        = ctl.pcen;
   assign wr_reg_src_o   = ctl.wrsrc;
   assign wr_reg_en_o    = ctl.wren;

endmodule

// File: tb/tb_rv64i_control_unit.sv
// Bench for rv64i_control_unit: directed scenarios plus randomized instruction
// streams compared against an instruction-semantics model of the controls.
module tb_rv64i_control_unit;

   localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111, BR = 7'b1100011, OPI = 7'b0010011;
   localparam logic [6:0] OPI32 = 7'b0011011, OPR = 7'b0110011, OPR32 = 7'b0111011;
   localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011;

   typedef struct packed {
      logic       rd;
      logic       wr;
      logic [7:0] be;
      logic       addr;
      logic       ir;
      logic       alua;
      logic       alub;
      logic       aluy;
      logic [2:0] alu;
      logic       sub;
      logic       arith;
      logic       alupc;
      logic       pcsrc;
      logic       pcen;
      logic [1:0] wrsrc;
      logic       wren;
   } ctl_t;

   logic       clock = 1'b0, reset = 1'b1;
   logic [6:0] opcode = '0, funct7 = '0;
   logic [2:0] funct3 = '0;
   logic       zero = 0, negative = 0, carry_out = 0, overflow = 0, mem_busy = 0;
   logic       mem_rd_en, mem_wr_en, mem_addr_src, ir_en, alua_src, alub_src, aluy_src;
   logic       sub, arithmetic, alupc_src, pc_src, pc_en, wr_reg_en;
   logic [7:0] mem_byte_en;
   logic [2:0] alu_src;
   logic [1:0] wr_reg_src;
   ctl_t       act;
   int         total = 0, bad = 0;

   rv64i_control_unit dut (
      .clock(clock), .reset(reset),
      .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
      .zero_i(zero), .negative_i(negative), .carry_out_i(carry_out),
      .overflow_i(overflow), .mem_busy_i(mem_busy),
      .mem_rd_en_o(mem_rd_en), .mem_wr_en_o(mem_wr_en), .mem_byte_en_o(mem_byte_en),
      .mem_addr_src_o(mem_addr_src), .ir_en_o(ir_en), .alua_src_o(alua_src),
      .alub_src_o(alub_src), .aluy_src_o(aluy_src), .alu_src_o(alu_src),
      .sub_o(sub), .arithmetic_o(arithmetic), .alupc_src_o(alupc_src),
      .pc_src_o(pc_src), .pc_en_o(pc_en), .wr_reg_src_o(wr_reg_src),
      .wr_reg_en_o(wr_reg_en)
   );

   assign act = {mem_rd_en, mem_wr_en, mem_byte_en, mem_addr_src, ir_en, alua_src,
                 alub_src, aluy_src, alu_src, sub, arithmetic, alupc_src, pc_src,
                 pc_en, wr_reg_src, wr_reg_en};

   initial forever #5 clock = ~clock;

   // Execute-phase controls derived from what each instruction means.
   function automatic ctl_t model(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic z, input logic n,
                                  input logic c, input logic v, input logic done);
      ctl_t e = '0;
      logic lt;
      int   nbytes;
      case (op)
         LUI:   begin e.wrsrc = 2'd3; e.wren = 1; e.pcen = 1; end
         AUIPC: begin e.alua = 1; e.alub = 1; e.wren = 1; e.pcen = 1; end
         JAL:   begin e.pcsrc = 1; e.wrsrc = 2'd2; e.wren = 1; e.pcen = 1; end
         JALR:  begin e.alub = 1; e.alupc = 1; e.pcsrc = 1; e.wrsrc = 2'd2; e.wren = 1; e.pcen = 1; end
         BR: begin
            e.sub = 1; e.pcen = 1; lt = n ^ v;
            case (f3)
               3'd0: e.pcsrc = z;      // beq
               3'd1: e.pcsrc = !z;     // bne
               3'd4: e.pcsrc = lt;     // blt
               3'd5: e.pcsrc = !lt;    // bge
               3'd6: e.pcsrc = !c;     // bltu: borrow means below
               3'd7: e.pcsrc = c;      // bgeu
               default: e.pcsrc = 0;
            endcase
         end
         OPI, OPI32, OPR, OPR32: begin
            e.alub  = (op == OPI || op == OPI32);
            e.aluy  = (op == OPI32 || op == OPR32);
            e.alu   = f3;
            e.arith = (f3 == 3'd5) && f7[5];
            e.sub   = (f3 == 3'd2) || (f3 == 3'd3) ||
                      ((op == OPR || op == OPR32) && f3 == 3'd0 && f7[5]);
            e.wren  = 1; e.pcen = 1;
         end
         LD, ST: begin
            nbytes = 1 << f3[1:0];
            e.be   = 8'((9'd1 << nbytes) - 9'd1);
            e.alub = 1; e.addr = 1;
            if (op == LD) e.wrsrc = 2'd1;
            if (done) begin e.pcen = 1; e.wren = (op == LD); end
            else begin e.rd = (op == LD); e.wr = (op == ST); end
         end
         default: e = '0;
      endcase
      return e;
   endfunction

   task automatic step();
      @(posedge clock); #1;
   endtask

   task automatic do_reset();
      reset = 1; mem_busy = 0; step(); step();
      reset = 0; step();
   endtask

   // From a Fetch cycle, run a fetch of 'lat' busy cycles and stop in Execute.
   task automatic fetch_to_exec(input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input int lat);
      mem_busy = 0; step();
      repeat (lat) begin mem_busy = 1; step(); end
      mem_busy = 0; opcode = op; funct3 = f3; funct7 = f7; step();
      step();
   endtask

   task automatic test_reset();
      ctl_t e;
      reset = 1; opcode = OPR; funct3 = 3'd5; funct7 = 7'h20; mem_busy = 1;
      step(); #1;
      if (act !== '0) begin bad++; $display("FAIL reset_hold: got %h exp 0", act); end
      total++;
      mem_busy = 0; reset = 0; #1;
      if (act !== '0) begin bad++; $display("FAIL reset_idle: got %h exp 0", act); end
      total++;
      step();
      e = '0; e.rd = 1; e.be = 8'h0F;
      if (act !== e) begin bad++; $display("FAIL reset_fetch: got %h exp %h", act, e); end
      total++;
   endtask

   task automatic test_fetch();
      ctl_t e;
      e = '0; e.rd = 1; e.be = 8'h0F;
      mem_busy = 0; #1;
      if (act !== e) begin bad++; $display("FAIL fetch_wait: got %h exp %h", act, e); end
      total++;
      step(); mem_busy = 1; #1;
      if (act !== e) begin bad++; $display("FAIL fetch_busy: got %h exp %h", act, e); end
      total++;
      step(); mem_busy = 1; step();
      mem_busy = 0; opcode = OPI; funct3 = 3'd0; funct7 = 7'h00; #1;
      e = '0; e.ir = 1; e.be = 8'h0F;
      if (act !== e) begin bad++; $display("FAIL fetch_ir: got %h exp %h", act, e); end
      total++;
      step();
      if (act !== '0) begin bad++; $display("FAIL decode: got %h exp 0", act); end
      total++;
      step();
      e = '0; e.alub = 1; e.wren = 1; e.pcen = 1;
      if (act !== e) begin bad++; $display("FAIL addi: got %h exp %h", act, e); end
      total++;
      step();
      e = '0; e.rd = 1; e.be = 8'h0F;
      if (act !== e) begin bad++; $display("FAIL addi_next: got %h exp %h", act, e); end
      total++;
   endtask

   task automatic test_alu();
      ctl_t e;
      fetch_to_exec(OPR, 3'd0, 7'h20, 1);
      e = '0; e.sub = 1; e.wren = 1; e.pcen = 1;
      if (act !== e) begin bad++; $display("FAIL sub: got %h exp %h", act, e); end
      total++;
      step();
      fetch_to_exec(OPI, 3'd5, 7'h20, 2);
      e = '0; e.alub = 1; e.alu = 3'd5; e.arith = 1; e.wren = 1; e.pcen = 1;
      if (act !== e) begin bad++; $display("FAIL srai: got %h exp %h", act, e); end
      total++;
      step();
      fetch_to_exec(OPR32, 3'd0, 7'h00, 1);
      e = '0; e.aluy = 1; e.wren = 1; e.pcen = 1;
      if (act !== e) begin bad++; $display("FAIL addw: got %h exp %h", act, e); end
      total++;
      step();
   endtask

   task automatic test_mem();
      ctl_t e;
      fetch_to_exec(LD, 3'd2, 7'h00, 1);
      e = '0; e.rd = 1; e.be = 8'h0F; e.addr = 1; e.alub = 1; e.wrsrc = 2'd1;
      mem_busy = 0; #1;
      if (act !== e) begin bad++; $display("FAIL lw_req: got %h exp %h", act, e); end
      total++;
      step(); mem_busy = 1; #1;
      if (act !== e) begin bad++; $display("FAIL lw_busy: got %h exp %h", act, e); end
      total++;
      step(); mem_busy = 0; #1;
      e.rd = 0; e.pcen = 1; e.wren = 1;
      if (act !== e) begin bad++; $display("FAIL lw_done: got %h exp %h", act, e); end
      total++;
      step();
      e = '0; e.rd = 1; e.be = 8'h0F;
      if (act !== e) begin bad++; $display("FAIL lw_next: got %h exp %h", act, e); end
      total++;
      fetch_to_exec(ST, 3'd3, 7'h00, 1);
      e = '0; e.wr = 1; e.be = 8'hFF; e.addr = 1; e.alub = 1;
      mem_busy = 1; #1;
      if (act !== e) begin bad++; $display("FAIL sd_req: got %h exp %h", act, e); end
      total++;
      step(); mem_busy = 0; #1;
      e.wr = 0; e.pcen = 1;
      if (act !== e) begin bad++; $display("FAIL sd_done: got %h exp %h", act, e); end
      total++;
      step();
   endtask

   task automatic test_branch();
      ctl_t e;
      fetch_to_exec(BR, 3'd0, 7'h00, 1);
      zero = 1; #1;
      e = '0; e.sub = 1; e.pcen = 1; e.pcsrc = 1;
      if (act !== e) begin bad++; $display("FAIL beq: got %h exp %h", act, e); end
      total++;
      zero = 0; #1;
      e.pcsrc = 0;
      if (act !== e) begin bad++; $display("FAIL beq_nt: got %h exp %h", act, e); end
      total++;
      step();
      fetch_to_exec(BR, 3'd6, 7'h00, 1);
      carry_out = 1; #1;
      if (act !== e) begin bad++; $display("FAIL bltu: got %h exp %h", act, e); end
      total++;
      carry_out = 0; step();
      fetch_to_exec(BR, 3'd5, 7'h00, 1);
      negative = 1; overflow = 0; #1;
      if (act !== e) begin bad++; $display("FAIL bge: got %h exp %h", act, e); end
      total++;
      negative = 0; step();
   endtask

   task automatic test_jump();
      ctl_t e;
      fetch_to_exec(JALR, 3'd0, 7'h00, 1);
      e = '0; e.alub = 1; e.alupc = 1; e.pcsrc = 1; e.wrsrc = 2'd2; e.wren = 1; e.pcen = 1;
      if (act !== e) begin bad++; $display("FAIL jalr: got %h exp %h", act, e); end
      total++;
      step();
      fetch_to_exec(LUI, 3'd7, 7'h7F, 1);
      e = '0; e.wrsrc = 2'd3; e.wren = 1; e.pcen = 1;
      if (act !== e) begin bad++; $display("FAIL lui: got %h exp %h", act, e); end
      total++;
      step();
   endtask

   task automatic test_random();
      logic [6:0] legal [11] = '{LUI, AUIPC, JAL, JALR, BR, OPI, OPI32, OPR, OPR32, LD, ST};
      logic [6:0] op, f7;
      logic [2:0] f3;
      ctl_t       e;
      for (int k = 0; k < 200; k++) begin
         op = legal[$urandom_range(0, 10)];
         f3 = 3'($urandom);
         f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'($urandom);
         mem_busy = 0; #1;
         e = '0; e.rd = 1; e.be = 8'h0F;
         if (act !== e) begin bad++; $display("FAIL rnd_fetch[%0d]: got %h exp %h", k, act, e); end
         total++;
         step();
         repeat ($urandom_range(1, 3)) begin mem_busy = 1; step(); end
         mem_busy = 0; opcode = op; funct3 = f3; funct7 = f7; #1;
         e = '0; e.ir = 1; e.be = 8'h0F;
         if (act !== e) begin bad++; $display("FAIL rnd_ir[%0d]: got %h exp %h", k, act, e); end
         total++;
         step();
         if (act !== '0) begin bad++; $display("FAIL rnd_decode[%0d]: got %h exp 0", k, act); end
         total++;
         step();
         if (op == LD || op == ST) begin
            repeat ($urandom_range(0, 2)) begin
               mem_busy = 0; #1;
               e = model(op, f3, f7, zero, negative, carry_out, overflow, 1'b0);
               if (act !== e) begin bad++; $display("FAIL rnd_mem_wait[%0d]: got %h exp %h", k, act, e); end
               total++;
               step();
            end
            repeat ($urandom_range(1, 3)) begin
               mem_busy = 1; #1;
               e = model(op, f3, f7, zero, negative, carry_out, overflow, 1'b0);
               if (act !== e) begin bad++; $display("FAIL rnd_mem_busy[%0d]: got %h exp %h", k, act, e); end
               total++;
               step();
            end
            mem_busy = 0;
         end
         {zero, negative, carry_out, overflow} = 4'($urandom); #1;
         e = model(op, f3, f7, zero, negative, carry_out, overflow, 1'b1);
         if (act !== e) begin bad++; $display("FAIL rnd_exec[%0d] op=%b f3=%0d: got %h exp %h", k, op, f3, act, e); end
         total++;
         step();
      end
   endtask

   task automatic test_halt();
      fetch_to_exec(7'h00, 3'd0, 7'h00, 1);
      if (act !== '0) begin bad++; $display("FAIL halt_exec: got %h exp 0", act); end
      total++;
      step();
      opcode = LUI;
      for (int k = 0; k < 6; k++) begin
         mem_busy = k[0]; #1;
         if (act !== '0) begin bad++; $display("FAIL halt_hold[%0d]: got %h exp 0", k, act); end
         total++;
         step();
      end
      mem_busy = 0;
   endtask

   task automatic test_reset_mid();
      ctl_t e;
      do_reset();
      mem_busy = 1; step();
      mem_busy = 0; reset = 1; #1;
      if (act !== '0) begin bad++; $display("FAIL rst_mid_fetch: got %h exp 0", act); end
      total++;
      step(); reset = 0; step();
      e = '0; e.rd = 1; e.be = 8'h0F;
      if (act !== e) begin bad++; $display("FAIL rst_flag_clear: got %h exp %h", act, e); end
      total++;
      fetch_to_exec(LD, 3'd0, 7'h00, 1);
      mem_busy = 1; step();
      mem_busy = 0; reset = 1; #1;
      if (act !== '0) begin bad++; $display("FAIL rst_mid_access: got %h exp 0", act); end
      total++;
      step(); reset = 0;
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_alu();
      test_mem();
      test_branch();
      test_jump();
      test_random();
      test_halt();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
